// File: rtl/reg_heap_ctrl.sv
// ID-stage core: 32x32 register heap (2 async read ports, 1 sync write port) plus main/ALU decoder.
// Define REGHEAP_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_heap_ctrl #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    addr_a,
  input  logic [4:0]    addr_b,
  input  logic [4:0]    addr_w,
  input  logic [DW-1:0] data_w,
  input  logic          write_reg,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b,
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic [15:0]   imm16,
  output logic          imm_s,
  output logic [31:0]   imm_ext,
  output logic          reg_write_ctl,
  output logic          reg_dst,
  output logic          alu_src,
  output logic [3:0]    alu_op,
  output logic          mem_read,
  output logic          mem_write,
  output logic          mem_to_reg,
  output logic          branch_eq,
  output logic          branch_ne,
  output logic          jump,
  output logic          jump_reg,
  output logic          link,
  output logic          illegal
);

  localparam int AW = $clog2(NREGS);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  logic [DW-1:0] reg_file [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        reg_file[i] <= '0;
      end
    end else if (write_reg && (addr_w != 5'd0)) begin
      reg_file[addr_w[AW-1:0]] <= data_w;
    end
  end

  // Register 0 is forced to zero on the read side, so its storage is never consulted.
  function automatic logic [DW-1:0] read_port(input logic [4:0] addr);
    logic [DW-1:0] val;
    val = reg_file[addr[AW-1:0]];
`ifdef REGHEAP_BYPASS_EN
    if (write_reg && (addr_w != 5'd0) && (addr_w == addr)) begin
      val = data_w;
    end
`else
`endif
    if (addr == 5'd0) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    data_a = read_port(addr_a);
    data_b = read_port(addr_b);
  end

  assign imm_ext = {{16{imm_s & imm16[15]}}, imm16};

  always_comb begin
    imm_s         = 1'b0;
    reg_write_ctl = 1'b0;
    reg_dst       = 1'b0;
    alu_src       = 1'b0;
    alu_op        = ALU_ADD;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    branch_eq     = 1'b0;
    branch_ne     = 1'b0;
    jump          = 1'b0;
    jump_reg      = 1'b0;
    link          = 1'b0;
    illegal       = 1'b0;
    case (opcode)
      6'h00: begin
        reg_dst       = 1'b1;
        reg_write_ctl = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_op = ALU_ADD;
          6'h22, 6'h23: alu_op = ALU_SUB;
          6'h24:        alu_op = ALU_AND;
          6'h25:        alu_op = ALU_OR;
          6'h26:        alu_op = ALU_XOR;
          6'h27:        alu_op = ALU_NOR;
          6'h2A:        alu_op = ALU_SLT;
          6'h2B:        alu_op = ALU_SLTU;
          6'h00:        alu_op = ALU_SLL;
          6'h02:        alu_op = ALU_SRL;
          6'h03:        alu_op = ALU_SRA;
          6'h08: begin
            jump_reg      = 1'b1;
            reg_write_ctl = 1'b0;
          end
          default: begin
            illegal       = 1'b1;
            reg_write_ctl = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09: begin
        alu_src = 1'b1; reg_write_ctl = 1'b1; imm_s = 1'b1; alu_op = ALU_ADD;
      end
      6'h0A: begin
        alu_src = 1'b1; reg_write_ctl = 1'b1; imm_s = 1'b1; alu_op = ALU_SLT;
      end
      6'h0B: begin
        alu_src = 1'b1; reg_write_ctl = 1'b1; imm_s = 1'b1; alu_op = ALU_SLTU;
      end
      6'h0C: begin
        alu_src = 1'b1; reg_write_ctl = 1'b1; alu_op = ALU_AND;
      end
      6'h0D: begin
        alu_src = 1'b1; reg_write_ctl = 1'b1; alu_op = ALU_OR;
      end
      6'h0E: begin
        alu_src = 1'b1; reg_write_ctl = 1'b1; alu_op = ALU_XOR;
      end
      6'h0F: begin
        alu_src = 1'b1; reg_write_ctl = 1'b1; alu_op = ALU_LUI;
      end
      6'h23: begin
        alu_src = 1'b1; imm_s = 1'b1; alu_op = ALU_ADD;
        mem_read = 1'b1; mem_to_reg = 1'b1; reg_write_ctl = 1'b1;
      end
      6'h2B: begin
        alu_src = 1'b1; imm_s = 1'b1; alu_op = ALU_ADD; mem_write = 1'b1;
      end
      6'h04: begin
        branch_eq = 1'b1; imm_s = 1'b1; alu_op = ALU_SUB;
      end
      6'h05: begin
        branch_ne = 1'b1; imm_s = 1'b1; alu_op = ALU_SUB;
      end
      6'h02: jump = 1'b1;
      6'h03: begin
        jump = 1'b1; link = 1'b1; reg_write_ctl = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_reg_heap_ctrl.sv
// Self-checking bench for reg_heap_ctrl: decode vector table, register-heap sequences,
// and a randomized run against a table-based behavioural model.
module tb_reg_heap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  addr_a, addr_b, addr_w;
  logic [31:0] data_w;
  logic        write_reg;
  logic [31:0] data_a, data_b;
  logic [5:0]  opcode, funct;
  logic [15:0] imm16;
  logic        imm_s;
  logic [31:0] imm_ext;
  logic        reg_write_ctl, reg_dst, alu_src;
  logic [3:0]  alu_op;
  logic        mem_read, mem_write, mem_to_reg;
  logic        branch_eq, branch_ne, jump, jump_reg, link, illegal;

  reg_heap_ctrl #(.NREGS(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .addr_a(addr_a), .addr_b(addr_b), .addr_w(addr_w),
    .data_w(data_w), .write_reg(write_reg),
    .data_a(data_a), .data_b(data_b),
    .opcode(opcode), .funct(funct), .imm16(imm16),
    .imm_s(imm_s), .imm_ext(imm_ext),
    .reg_write_ctl(reg_write_ctl), .reg_dst(reg_dst), .alu_src(alu_src),
    .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump),
    .jump_reg(jump_reg), .link(link), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // flags order: rwc reg_dst alu_src | mem_read mem_write mem_to_reg | beq bne jump | jr link illegal
  logic [11:0] dut_flags;
  assign dut_flags = {reg_write_ctl, reg_dst, alu_src, mem_read, mem_write, mem_to_reg,
                      branch_eq, branch_ne, jump, jump_reg, link, illegal};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic        s;
    logic [31:0] ext;
    logic [3:0]  aop;
    logic [11:0] flags;
  } vec_t;

  typedef struct {
    logic        s;
    logic [31:0] ext;
    logic [3:0]  aop;
    logic [11:0] flags;
  } dec_t;

  int tests = 0;
  int fails = 0;
  logic [31:0] mem [32];
  int r_alu [64];
  int i_alu [8];
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decoder reference: table lookups for ALU selection, instruction classes for the rest.
  function automatic dec_t model_dec(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] imm);
    dec_t d;
    logic rwc, rd, as, mr, mw, mtr, beq, bne, j, jr, lk, ill;
    int o;
    int f;
    o = int'(op);
    f = int'(fn);
    {rwc, rd, as, mr, mw, mtr, beq, bne, j, jr, lk, ill} = '0;
    d.s = 1'b0;
    d.aop = 4'd0;
    if (o == 0) begin
      rd = 1'b1;
      if (f == 8) jr = 1'b1;
      else if (r_alu[f] >= 0) begin rwc = 1'b1; d.aop = 4'(r_alu[f]); end
      else ill = 1'b1;
    end else if (o >= 8 && o <= 15) begin
      as = 1'b1; rwc = 1'b1; d.aop = 4'(i_alu[o-8]); d.s = (o <= 11);
    end else if (o == 35 || o == 43) begin
      as = 1'b1; d.s = 1'b1; mr = (o == 35); mtr = mr; rwc = mr; mw = (o == 43);
    end else if (o == 4 || o == 5) begin
      d.s = 1'b1; d.aop = 4'd1; beq = (o == 4); bne = (o == 5);
    end else if (o == 2 || o == 3) begin
      j = 1'b1; lk = (o == 3); rwc = lk;
    end else begin
      ill = 1'b1;
    end
    d.flags = {rwc, rd, as, mr, mw, mtr, beq, bne, j, jr, lk, ill};
    d.ext = (d.s && imm[15]) ? (32'hFFFF0000 | 32'(imm)) : 32'(imm);
    return d;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef REGHEAP_BYPASS_EN
    if (write_reg && addr_w != 5'd0 && addr_w == a) return data_w;
`endif
    return mem[a];
  endfunction

  task automatic clock_edge();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 32; k++) mem[k] = 32'd0;
    end else if (write_reg && addr_w != 5'd0) begin
      mem[addr_w] = data_w;
    end
    #1;
  endtask

  task automatic do_write(input logic r, input logic we, input logic [4:0] aw, input logic [31:0] dw);
    rst = r; write_reg = we; addr_w = aw; data_w = dw;
    clock_edge();
    rst = 1'b0; write_reg = 1'b0;
    $display("[TB] edge rst=%0b we=%0b addr_w=%0d data_w=%h", r, we, aw, dw);
  endtask

  logic [5:0] legal_ops [15];
  logic [5:0] legal_fns [15];

  initial begin
    dec_t d;
    logic [31:0] exp_old;

    for (int k = 0; k < 64; k++) r_alu[k] = -1;
    r_alu[32] = 0; r_alu[33] = 0; r_alu[34] = 1; r_alu[35] = 1;
    r_alu[36] = 2; r_alu[37] = 3; r_alu[38] = 4; r_alu[39] = 5;
    r_alu[42] = 6; r_alu[43] = 7; r_alu[0] = 8; r_alu[2] = 9; r_alu[3] = 10;
    i_alu = '{0, 0, 6, 7, 2, 3, 4, 11};
    legal_ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                  6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    legal_fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h01};

    vecs[0]  = '{6'h08, 6'h00, 16'h8001, 1'b1, 32'hFFFF8001, 4'd0,  12'b101_000_000_000};
    vecs[1]  = '{6'h0D, 6'h00, 16'h8001, 1'b0, 32'h00008001, 4'd3,  12'b101_000_000_000};
    vecs[2]  = '{6'h23, 6'h00, 16'h0010, 1'b1, 32'h00000010, 4'd0,  12'b101_101_000_000};
    vecs[3]  = '{6'h00, 6'h2A, 16'h0000, 1'b0, 32'h00000000, 4'd6,  12'b110_000_000_000};
    vecs[4]  = '{6'h04, 6'h00, 16'hFFFF, 1'b1, 32'hFFFFFFFF, 4'd1,  12'b000_000_100_000};
    vecs[5]  = '{6'h3F, 6'h00, 16'h8000, 1'b0, 32'h00008000, 4'd0,  12'b000_000_000_001};
    vecs[6]  = '{6'h03, 6'h00, 16'h1234, 1'b0, 32'h00001234, 4'd0,  12'b100_000_001_010};
    vecs[7]  = '{6'h00, 6'h08, 16'h0000, 1'b0, 32'h00000000, 4'd0,  12'b010_000_000_100};
    vecs[8]  = '{6'h00, 6'h01, 16'h0000, 1'b0, 32'h00000000, 4'd0,  12'b010_000_000_001};
    vecs[9]  = '{6'h2B, 6'h00, 16'h8000, 1'b1, 32'hFFFF8000, 4'd0,  12'b001_010_000_000};
    vecs[10] = '{6'h0F, 6'h00, 16'h8000, 1'b0, 32'h00008000, 4'd11, 12'b101_000_000_000};
    vecs[11] = '{6'h00, 6'h03, 16'h0000, 1'b0, 32'h00000000, 4'd10, 12'b110_000_000_000};

    rst = 1'b1; write_reg = 1'b0; addr_a = '0; addr_b = '0; addr_w = '0; data_w = '0;
    opcode = '0; funct = '0; imm16 = '0;
    clock_edge();
    clock_edge();
    rst = 1'b0;

    // Reset state: every register reads zero on both ports.
    for (int k = 0; k < 32; k++) begin
      addr_a = 5'(k); addr_b = 5'(31 - k); #1;
      check("reset_a", data_a, 32'd0);
      check("reset_b", data_b, 32'd0);
    end
    $display("[TB] reset state scanned");

    // Decode table.
    for (int k = 0; k < 12; k++) begin
      opcode = vecs[k].op; funct = vecs[k].fn; imm16 = vecs[k].imm; #1;
      check("vec_sflags", {19'd0, imm_s, dut_flags}, {19'd0, vecs[k].s, vecs[k].flags});
      check("vec_ext", imm_ext, vecs[k].ext);
      check("vec_aluop", {28'd0, alu_op}, {28'd0, vecs[k].aop});
      $display("[TB] vec %0d op=%h fn=%h imm=%h -> s=%0b ext=%h aop=%0d flags=%b",
               k, opcode, funct, imm16, imm_s, imm_ext, alu_op, dut_flags);
    end

    // Reset clears a written register.
    do_write(1'b0, 1'b1, 5'd5, 32'h12345678);
    addr_a = 5'd5; #1;
    check("r5_written", data_a, 32'h12345678);
    do_write(1'b1, 1'b0, 5'd0, 32'd0);
    addr_a = 5'd5; #1;
    check("r5_after_rst", data_a, 32'd0);

    // Write/read at both ends of the address range, on both ports.
    do_write(1'b0, 1'b1, 5'd31, 32'hDEADBEEF);
    do_write(1'b0, 1'b1, 5'd1, 32'hA5A5A5A5);
    addr_a = 5'd31; addr_b = 5'd1; #1;
    check("r31_a", data_a, 32'hDEADBEEF);
    check("r1_b", data_b, 32'hA5A5A5A5);
    addr_a = 5'd1; addr_b = 5'd31; #1;
    check("r1_a", data_a, 32'hA5A5A5A5);
    check("r31_b", data_b, 32'hDEADBEEF);

    // r0 is immutable; reset beats a simultaneous write.
    do_write(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    addr_a = 5'd0; addr_b = 5'd0; #1;
    check("r0_a", data_a, 32'd0);
    check("r0_b", data_b, 32'd0);
    do_write(1'b1, 1'b1, 5'd3, 32'h0000CAFE);
    addr_a = 5'd3; #1;
    check("rst_beats_wr", data_a, 32'd0);

    // Same-cycle read of the address being written.
    do_write(1'b0, 1'b1, 5'd7, 32'h00000011);
    addr_a = 5'd7; addr_b = 5'd7; write_reg = 1'b1; addr_w = 5'd7; data_w = 32'h55; #1;
`ifdef REGHEAP_BYPASS_EN
    exp_old = 32'h55;
`else
    exp_old = 32'h11;
`endif
    check("same_cycle_a", data_a, exp_old);
    check("same_cycle_b", data_b, exp_old);
    clock_edge();
    write_reg = 1'b0;
    check("after_edge_a", data_a, 32'h55);
    $display("[TB] same-cycle r7 read=%h after edge=%h", exp_old, data_a);
    addr_a = 5'd0; write_reg = 1'b1; addr_w = 5'd0; data_w = 32'hFFFF0000; #1;
    check("r0_no_fwd", data_a, 32'd0);
    write_reg = 1'b0;

    // Randomized run against the reference models.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 40) == 0);
      write_reg = $urandom_range(0, 1);
      addr_w    = 5'($urandom);
      data_w    = $urandom;
      addr_a    = ($urandom_range(0, 3) == 0) ? addr_w : 5'($urandom);
      addr_b    = ($urandom_range(0, 3) == 0) ? addr_w : 5'($urandom);
      opcode    = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 14)] : 6'($urandom);
      funct     = ($urandom_range(0, 3) != 0) ? legal_fns[$urandom_range(0, 14)] : 6'($urandom);
      imm16     = 16'($urandom);
      #2;
      d = model_dec(opcode, funct, imm16);
      check("rnd_sflags", {19'd0, imm_s, dut_flags}, {19'd0, d.s, d.flags});
      check("rnd_ext", imm_ext, d.ext);
      check("rnd_aluop", {28'd0, alu_op}, {28'd0, d.aop});
      check("rnd_data_a", data_a, model_read(addr_a));
      check("rnd_data_b", data_b, model_read(addr_b));
      $display("[TB] rnd %0d op=%h fn=%h rst=%0b we=%0b aw=%0d a=%0d:%h b=%0d:%h",
               n, opcode, funct, rst, write_reg, addr_w, addr_a, data_a, addr_b, data_b);
      clock_edge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_heap_ctrl.md
Name: reg_heap_ctrl

Overview:
Instruction-decode core of the 5-stage CPU's ID stage. Combines the 32x32 general-purpose register heap (two combinational read ports, one synchronous write port) with the combinational main/ALU decoder. The decoder turns opcode/funct into datapath control, including the immediate sign-extend select imm_s. The ID-stage wrapper feeds IR fields in and receives operands, the extended immediate and control.

Parameters:
NREGS, 32, number of registers; must be a power of two, address width log2(NREGS)=5.
DW, 32, register/data width.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  synchronous active-high reset.
addr_a  in  5  read address A (IR[25:21]).
addr_b  in  5  read address B (IR[20:16]).
addr_w  in  5  write-back address.
data_w  in  32  write-back data.
write_reg  in  1  write-back enable.
data_a  out  32  register[addr_a].
data_b  out  32  register[addr_b].
opcode  in  6  IR[31:26].
funct  in  6  IR[5:0].
imm16  in  16  IR[15:0].
imm_s  out  1  1 = sign-extend the immediate, 0 = zero-extend it.
imm_ext  out  32  extended immediate.
reg_write_ctl  out  1  instruction writes a register.
reg_dst  out  1  1 = rd destination, 0 = rt destination.
alu_src  out  1  1 = ALU B input is the immediate.
alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI.
mem_read, mem_write, mem_to_reg  out  1 each  load/store control.
branch_eq, branch_ne, jump, jump_reg, link  out  1 each  flow control.
illegal  out  1  unrecognised opcode or funct.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named rst.
- Register heap storage: 32 x 32-bit. On a rising clk with rst=1, all registers clear to 0. Reset wins over a simultaneous write.
- Register write: on a rising clk with rst=0 and write_reg=1, register[addr_w] <= data_w. Writes to address 0 are discarded.
- Register reads: combinational. Address 0 always reads 0. Without the bypass feature, a read in the same cycle as a write to that address returns the old value; the new value appears after the edge.
- Decoder: purely combinational and unaffected by rst. All outputs are 0 by default.
- imm_ext = {16{imm_s & imm16[15]}, imm16}.
- R-type (opcode 0x00): reg_dst=1, reg_write_ctl=1, alu_src=0. funct mapping:
  - 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x2A SLT; 0x2B SLTU.
  - 0x00 SLL; 0x02 SRL; 0x03 SRA.
  - 0x08 jr: jump_reg=1, reg_write_ctl=0.
  - Any other funct: illegal=1, reg_write_ctl=0.
- I-type arithmetic/logic: alu_src=1, reg_write_ctl=1, reg_dst=0.
  - 0x08/0x09 ADD with imm_s=1.
  - 0x0A SLT and 0x0B SLTU, both with imm_s=1.
  - 0x0C AND, 0x0D OR, 0x0E XOR, all with imm_s=0.
  - 0x0F LUI with imm_s=0.
- Loads and stores:
  - 0x23 lw: alu_src=1, imm_s=1, ADD, mem_read=1, mem_to_reg=1, reg_write_ctl=1.
  - 0x2B sw: alu_src=1, imm_s=1, ADD, mem_write=1.
- Branches: 0x04 beq sets branch_eq=1; 0x05 bne sets branch_ne=1. Both use SUB with imm_s=1.
- Jumps: 0x02 j sets jump=1. 0x03 jal sets jump=1, link=1, reg_write_ctl=1.
- Any other opcode: illegal=1 and all enables 0.

Optional Feature:
REGHEAP_BYPASS_EN.
- Defined: when write_reg=1 and addr_w!=0, a read port whose address equals addr_w returns data_w combinationally in the same cycle (write-through forwarding).
- Undefined: reads return stored contents only.
- Register 0 reads 0 in both builds.

Test Plan:
- Reset: write 0x12345678 to r5, assert rst for one edge -> data_a reads 0 at addr_a=5; all registers read 0.
- Write/read: write 0xDEADBEEF to r31 and 0xA5A5A5A5 to r1 -> after the edges, addr_a=31/addr_b=1 return those values on both ports.
- r0: write 0xFFFFFFFF to r0 -> reads 0. A simultaneous rst=1 with a write to r3 -> r3 stays 0.
- Same-cycle read of the write address: writing 0x55 to r7 while addr_a=7 -> old value without REGHEAP_BYPASS_EN, 0x55 with it.
- Immediate extension: addi (0x08) with imm16=0x8001 -> imm_s=1, imm_ext=0xFFFF8001. ori (0x0D) with 0x8001 -> imm_s=0, imm_ext=0x00008001.
- Decode: lw gives mem_read=mem_to_reg=reg_write_ctl=alu_src=1. R-type funct 0x2A gives alu_op=6, reg_dst=1. beq gives branch_eq=1, alu_op=1. opcode 0x3F gives illegal=1 with every enable 0.
